// File: rtl/serial_adder_arbiter.sv
// Two-requester front end for a single bit-serial adder cell: round-robin grant,
// operand capture, LSB-first sequencing over WIDTH cycles, valid/ready result return.
//
// state | meaning
// IDLE  | waiting for a request; grants and captures operands of the winner
// RUN   | one sum bit per cycle through the half-adder pair, LSB first
// DONE  | result held on res_* until res_ready is seen
module serial_adder_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   output logic             gnt0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt1,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             res_id,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_last;
   logic             r_id;
   logic             r_gnt0;
   logic             r_gnt1;
   logic             r_res_valid;
   logic [WIDTH-1:0] r_res_sum;
   logic             r_res_cout;
   logic             r_res_id;

   logic             w_win_valid;
   logic             w_win_id;
   logic             w_ha1_s;
   logic             w_ha1_c;
   logic             w_ha2_s;
   logic             w_ha2_c;
   logic             w_carry_next;
   logic [WIDTH-1:0] w_sum_next;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      w_win_valid = req0 | req1;
      w_win_id    = (req0 && req1) ? ~r_last : req1;
   end

   always_comb begin
      w_ha1_s      = r_a[0] ^ r_b[0];
      w_ha1_c      = r_a[0] & r_b[0];
      w_ha2_s      = w_ha1_s ^ r_carry;
      w_ha2_c      = w_ha1_s & r_carry;
      w_carry_next = w_ha1_c | w_ha2_c;
      w_sum_next   = {w_ha2_s, r_sum[WIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_last      <= 1'b1;
         r_id        <= 1'b0;
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_sum   <= '0;
         r_res_cout  <= 1'b0;
         r_res_id    <= 1'b0;
      end else begin
         r_gnt0 <= 1'b0;
         r_gnt1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_win_valid) begin
                  r_a     <= w_win_id ? a1 : a0;
                  r_b     <= w_win_id ? b1 : b0;
                  r_gnt0  <= ~w_win_id;
                  r_gnt1  <= w_win_id;
                  r_id    <= w_win_id;
                  r_last  <= w_win_id;
                  r_carry <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_sum   <= w_sum_next;
               r_carry <= w_carry_next;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_res_sum   <= w_sum_next;
                  r_res_cout  <= w_carry_next;
                  r_res_id    <= r_id;
                  r_res_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (r_res_valid && res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt0      = r_gnt0;
   assign gnt1      = r_gnt1;
   assign res_valid = r_res_valid;
   assign res_sum   = r_res_sum;
   assign res_cout  = r_res_cout;
   assign res_id    = r_res_id;
   assign busy      = (r_state == S_RUN) || (r_state == S_DONE);

endmodule

// File: doc/serial_adder_arbiter.md
Name: serial_adder_arbiter

Overview:
- Shares one bit-serial adder cell between two requesters. The cell is built from two half adders plus an OR gate for carry.
- Arbitrates requests round-robin, captures the winner's operands and sequences the cell over WIDTH cycles.
- Returns sum, carry-out and requester ID through a valid/ready handshake.
- Sits between the tile pin mapping and the adder datapath. It is the sequencing layer above the single-bit sum/carry logic.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..16.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous active-high reset.
- req0  in  1  requester 0 request; hold high with operands stable until gnt0 is seen.
- a0  in  WIDTH  requester 0 operand A.
- b0  in  WIDTH  requester 0 operand B.
- gnt0  out  1  one-cycle pulse: requester 0 operands captured.
- req1  in  1  requester 1 request, same rules as req0.
- a1  in  WIDTH  requester 1 operand A.
- b1  in  WIDTH  requester 1 operand B.
- gnt1  out  1  one-cycle pulse: requester 1 operands captured.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_sum  out  WIDTH  sum, modulo 2^WIDTH.
- res_cout  out  1  carry out of the MSB.
- res_id  out  1  ID of the requester that owns the result.
- busy  out  1  high in states RUN and DONE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - gnt0, gnt1, res_valid, res_sum, res_cout, res_id, busy all 0.
  - Internal carry=0, bit counter=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, that requester wins.
  - If both are high, the requester not equal to last wins.
  - On the clock edge, for the winner:
    - capture its a/b into shift registers;
    - set the matching gnt high for exactly the next cycle;
    - record the winner ID, set last=winner;
    - clear carry and counter;
    - go to RUN.
- RUN (one bit per cycle, LSB first):
  - Bit computation:
    - half adder 1: p=a[i]^b[i], g=a[i]&b[i];
    - half adder 2: s=p^carry, carry_next=g|(p&carry).
  - Each edge, s shifts into the sum register from the MSB side, both operand registers shift right, and the counter increments.
  - On the edge where counter==WIDTH-1:
    - load res_sum from the completed sum;
    - load res_cout from carry_next and res_id from the winner ID;
    - set res_valid=1 and go to DONE.
- Latency: res_valid rises exactly WIDTH cycles after the cycle in which gnt is high.
- DONE:
  - res_valid, res_sum, res_cout and res_id hold stable while res_ready=0.
  - No grants are issued, even if req is high.
  - On an edge with res_valid&&res_ready, clear res_valid and go to IDLE.
  - A new grant happens no earlier than the following edge, so an op occupies at least WIDTH+2 cycles.
- Result outputs change only on entry to DONE. After the handshake they keep their last values until the next DONE entry.
- A requester that drops req before gnt is not served and leaves no state behind. Operand changes after the capture edge are ignored.
- Asserting rst in any state abandons the operation at once:
  - no res_valid and no gnt are produced for it;
  - the pointer returns to last=1.
- gnt0 and gnt1 are never high in the same cycle. At most one op is in flight.

Test Plan:
- Reset: assert rst while driving random req/operands -> all outputs read 0; after release with req idle, busy stays 0 indefinitely.
- Single op, WIDTH=8: req0=1, a0=0x5A, b0=0x3C, res_ready=1.
  - gnt0 pulses for one cycle; res_valid rises 8 cycles later.
  - Result: res_sum=0x96, res_cout=0, res_id=0; busy deasserts after the handshake.
- Overflow: req1=1, a1=0xFF, b1=0x01 -> res_sum=0x00, res_cout=1, res_id=1. Also a=0xFF, b=0xFF -> res_sum=0xFE, res_cout=1.
- Arbitration:
  - req0 and req1 held high together from reset -> grant order 0,1,0,1.
  - Then only req1 high for two consecutive ops -> grants 1,1.
- Backpressure: hold res_ready=0 for 5 cycles in DONE with req0 high -> res_valid and result stay constant and no gnt occurs; raising res_ready completes the handshake, then gnt0 follows.
- Reset mid-RUN: assert rst 3 cycles after gnt0 -> busy=0 and res_valid=0 immediately and no result emerges; the next request 0x10+0x20 yields 0x30.
